// File: rtl/csa_3to2_pipe.sv
// Registered 3:2 carry-save compressor with per-beat compress or running accumulate.
// Latency: 1 cycle from an output-producing beat to out_valid.
// Backpressure: in_ready drops while a held result is not taken; out_ready->in_ready is the only comb path.
module csa_3to2_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_carry,
    output logic [CNT_W-1:0] out_count
);

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
    } csa_t;

    // Carry row is pre-shifted; the carry out of the MSB column is dropped.
    function automatic csa_t compress(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y,
                                      input logic [WIDTH-1:0] z);
        csa_t             r;
        logic [WIDTH-1:0] m;
        r.s = x ^ y ^ z;
        m   = (x & y) | (x & z) | (y & z);
        r.c = {m[WIDTH-2:0], 1'b0};
        return r;
    endfunction

    logic [WIDTH-1:0] acc_s;
    logic [WIDTH-1:0] acc_c;
    logic [CNT_W-1:0] acc_n;
    csa_t             l1;
    csa_t             l2;
    csa_t             l3;
    logic [CNT_W-1:0] n_next;
    logic             accept;
    logic             take;

    always_comb begin
        l1     = compress(in_a, in_b, in_c);
        l2     = compress(l1.s, l1.c, acc_s);
        l3     = compress(l2.s, l2.c, acc_c);
        n_next = (acc_n == {CNT_W{1'b1}}) ? acc_n : acc_n + CNT_W'(1);
    end

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign take     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= '0;
            out_count <= '0;
            acc_s     <= '0;
            acc_c     <= '0;
            acc_n     <= '0;
        end else begin
            if (take) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (!in_mode) begin
                    // Accumulator deliberately untouched so mode-0 beats can interleave.
                    out_sum   <= l1.s;
                    out_carry <= l1.c;
                    out_count <= CNT_W'(1);
                    out_valid <= 1'b1;
                end else if (in_last) begin
                    out_sum   <= l3.s;
                    out_carry <= l3.c;
                    out_count <= n_next;
                    out_valid <= 1'b1;
                    acc_s     <= '0;
                    acc_c     <= '0;
                    acc_n     <= '0;
                end else begin
                    acc_s <= l3.s;
                    acc_c <= l3.c;
                    acc_n <= n_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_csa_3to2_pipe.sv
// Directed bench for csa_3to2_pipe at WIDTH=8, CNT_W=2 (small counter exposes saturation).
module tb_csa_3to2_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] in_c;
    logic       in_mode;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [7:0] out_carry;
    logic [1:0] out_count;
    logic [7:0] total;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_3to2_pipe #(.WIDTH(8), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    assign total = out_sum + out_carry;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat, waits (bounded) for in_ready, then returns #1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic mode, input logic last);
        int k;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_mode  = mode;
        in_last  = last;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        check("send_timeout", 32'(k < 20), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        in_mode   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        #1;
        check("first_in_ready", 32'(in_ready), 32'd1);

        // Mode-0 compress
        send(8'h0F, 8'h33, 8'h55, 1'b0, 1'b0);
        check("cmp_valid", 32'(out_valid), 32'd1);
        check("cmp_sum",   32'(out_sum),   32'h69);
        check("cmp_carry", 32'(out_carry), 32'h2E);
        check("cmp_count", 32'(out_count), 32'd1);
        check("cmp_total", 32'(total),     32'h97);

        // Wrap; accepted in the same cycle the previous result is taken
        send(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        check("wrap_valid", 32'(out_valid), 32'd1);
        check("wrap_sum",   32'(out_sum),   32'hFF);
        check("wrap_carry", 32'(out_carry), 32'hFE);
        check("wrap_total", 32'(total),     32'hFD);
        send(8'h01, 8'h02, 8'h04, 1'b0, 1'b0);
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_sum",   32'(out_sum),   32'h07);
        check("b2b_carry", 32'(out_carry), 32'h00);
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Accumulate three beats
        send(8'd1, 8'd2, 8'd3, 1'b1, 1'b0);
        check("acc1_no_valid", 32'(out_valid), 32'd0);
        send(8'd4, 8'd5, 8'd6, 1'b1, 1'b0);
        check("acc2_no_valid", 32'(out_valid), 32'd0);
        send(8'd7, 8'd8, 8'd9, 1'b1, 1'b1);
        check("acc_valid",  32'(out_valid),    32'd1);
        check("acc_total",  32'(total),        32'h2D);
        check("acc_count",  32'(out_count),    32'd3);
        check("acc_c_lsb",  32'(out_carry[0]), 32'd0);
        tick();

        // Interleaved mode-0 beat under backpressure
        send(8'd1, 8'd2, 8'd3, 1'b1, 1'b0);
        out_ready = 1'b0;
        send(8'h10, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_sum",      32'(out_sum),   32'h10);
            check("bp_count",    32'(out_count), 32'd1);
            check("bp_in_ready", 32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_taken", 32'(out_valid), 32'd0);
        send(8'd4, 8'd5, 8'd6, 1'b1, 1'b1);
        check("il_valid", 32'(out_valid), 32'd1);
        check("il_total", 32'(total),     32'h15);
        check("il_count", 32'(out_count), 32'd2);
        tick();

        // Reset mid-accumulation discards the open stream
        send(8'd9, 8'd9, 8'd9, 1'b1, 1'b0);
        send(8'd7, 8'd7, 8'd7, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("mrst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("mrst_after_valid", 32'(out_valid), 32'd0);
        send(8'd1, 8'd1, 8'd1, 1'b1, 1'b1);
        check("mrst_res_valid", 32'(out_valid), 32'd1);
        check("mrst_total",     32'(total),     32'd3);
        check("mrst_count",     32'(out_count), 32'd1);
        tick();

        // Counter saturation at 3 with CNT_W=2
        for (int i = 0; i < 4; i++) begin
            send(8'd1, 8'd0, 8'd0, 1'b1, 1'b0);
            check("sat_no_valid", 32'(out_valid), 32'd0);
        end
        send(8'd1, 8'd0, 8'd0, 1'b1, 1'b1);
        check("sat_valid", 32'(out_valid), 32'd1);
        check("sat_total", 32'(total),     32'd5);
        check("sat_count", 32'(out_count), 32'd3);
        tick();
        check("sat_drain", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
